// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan driver.
// Holds the scan FSM encoding and the blank segment constant.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GUARD,
    ST_SHOW,
    ST_DIM
  } state_t;

  localparam int SEG_MAX_W = 32;
  localparam logic [SEG_MAX_W-1:0] SEG_BLANK = '1;

endpackage

// File: rtl/seg_prescaler.sv
// Scan tick generator: one-cycle tick every TICK_DIV clk_disp cycles.
// TICK_DIV of 1 keeps the counter at zero, so tick is held high.
module seg_prescaler #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk_disp,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Free-running divider that wraps on the tick cycle.
  always_ff @(posedge clk_disp or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver with per-slot PWM brightness.
// Each slot is a blank guard phase followed by SHOW then DIM phases.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS = 4,
  parameter int SEG_W    = 7,
  parameter int TICK_DIV = 50000,
  parameter int BRIGHT_W = 2,
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                      clk_disp,
  input  logic                      rst,
  input  logic [N_DIGITS*SEG_W-1:0] seg_in,
  input  logic [N_DIGITS-1:0]       dp_in,
  input  logic [N_DIGITS-1:0]       digit_en,
  input  logic [BRIGHT_W-1:0]       bright,
  output logic [SEG_W-1:0]          seg_out,
  output logic                      dp_out,
  output logic [N_DIGITS-1:0]       sel,
  output logic [IW-1:0]             scan_idx,
  output logic                      frame_done
);

  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] PH_LAST = '1;
  localparam logic [SEG_W-1:0] BLANK = SEG_BLANK[SEG_W-1:0];

  logic tick;

  state_t state, state_n;
  logic [BRIGHT_W-1:0] phase, phase_n;
  logic [BRIGHT_W-1:0] bright_l;
  logic [IW-1:0] idx_n;
  logic [SEG_W-1:0] seg_l, seg_n;
  logic dp_l, dp_n, en_l;
  logic [N_DIGITS-1:0] sel_n;
  logic latch, wrap, show;

  seg_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk_disp(clk_disp),
    .rst     (rst),
    .tick    (tick)
  );

  // Next slot position and the registered output values it implies.
  always_comb begin
    state_n = state;
    phase_n = phase;
    idx_n   = scan_idx;
    latch   = 1'b0;
    wrap    = 1'b0;
    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          state_n = ST_GUARD;
          phase_n = '0;
          idx_n   = '0;
          latch   = 1'b1;
        end
        default: begin
          if (phase == PH_LAST) begin
            state_n = ST_GUARD;
            phase_n = '0;
            latch   = 1'b1;
            if (scan_idx == IDX_LAST) begin
              idx_n = '0;
              wrap  = 1'b1;
            end else begin
              idx_n = scan_idx + IW'(1);
            end
          end else begin
            phase_n = phase + BRIGHT_W'(1);
            state_n = (phase_n <= bright_l) ? ST_SHOW : ST_DIM;
          end
        end
      endcase
    end
    // Latched values are only stale on a latch edge, which is GUARD.
    show  = (state_n == ST_SHOW) && en_l;
    sel_n = show ? (N_DIGITS'(1) << idx_n) : '0;
    seg_n = show ? seg_l : BLANK;
    dp_n  = show ? dp_l : 1'b1;
  end

  // Scan position and the per-slot snapshot taken at the guard phase.
  always_ff @(posedge clk_disp or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      phase    <= '0;
      scan_idx <= '0;
      seg_l    <= BLANK;
      dp_l     <= 1'b1;
      en_l     <= 1'b0;
      bright_l <= '0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      scan_idx <= idx_n;
      if (latch) begin
        seg_l    <= seg_in[idx_n*SEG_W +: SEG_W];
        dp_l     <= dp_in[idx_n];
        en_l     <= digit_en[idx_n];
        bright_l <= bright;
      end
    end
  end

  // Registered display drive, updated on the same edge as the scan.
  always_ff @(posedge clk_disp or posedge rst) begin
    if (rst) begin
      seg_out    <= BLANK;
      dp_out     <= 1'b1;
      sel        <= '0;
      frame_done <= 1'b0;
    end else begin
      seg_out    <= seg_n;
      dp_out     <= dp_n;
      sel        <= sel_n;
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with a per-cycle expectation queue.
// Four digits, tick every cycle, four-phase slots, sixteen-cycle frames.
module tb_seg_scan_driver;

  logic        clk_disp;
  logic        rst;
  logic [27:0] seg_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [1:0]  bright;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  sel;
  logic [1:0]  scan_idx;
  logic        frame_done;

  seg_scan_driver #(
    .N_DIGITS(4),
    .SEG_W   (7),
    .TICK_DIV(1),
    .BRIGHT_W(2)
  ) dut (
    .clk_disp  (clk_disp),
    .rst       (rst),
    .seg_in    (seg_in),
    .dp_in     (dp_in),
    .digit_en  (digit_en),
    .bright    (bright),
    .seg_out   (seg_out),
    .dp_out    (dp_out),
    .sel       (sel),
    .scan_idx  (scan_idx),
    .frame_done(frame_done)
  );

  initial clk_disp = 1'b0;
  always #5 clk_disp = ~clk_disp;

  typedef struct {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  exp_t q[$];

  int tot = 0;
  int bad = 0;
  int p = -1;
  int cy = 0;
  int last_fd = -1;
  int hits;

  logic [6:0] m_seg;
  logic       m_dp;
  logic       m_en;
  int         m_br;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    exp_t e;
    exp_t o;
    int ph;
    int sl;
    @(posedge clk_disp);
    cy++;
    if (rst) p = -1;
    else if (p < 0) p = 0;
    else p++;
    e.sel = 4'h0;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.idx = 2'd0;
    e.fd  = 1'b0;
    if (p >= 0) begin
      ph = p % 4;
      sl = (p / 4) % 4;
      if (ph == 0) begin
        m_seg = seg_in[sl*7 +: 7];
        m_dp  = dp_in[sl];
        m_en  = digit_en[sl];
        m_br  = int'(bright);
      end
      if (ph >= 1 && ph <= m_br && m_en) begin
        e.sel = 4'h1 << sl;
        e.seg = m_seg;
        e.dp  = m_dp;
      end
      e.idx = 2'(sl);
      e.fd  = (p > 0) && (p % 16 == 0);
    end
    q.push_back(e);
    @(negedge clk_disp);
    if (q.size() == 0) begin
      chk("queue_empty", 32'd0, 32'd1);
    end else begin
      o = q.pop_front();
      chk("sel", sel, o.sel);
      chk("seg_out", seg_out, o.seg);
      chk("dp_out", dp_out, o.dp);
      chk("scan_idx", scan_idx, o.idx);
      chk("frame_done", frame_done, o.fd);
    end
    chk("sel_onehot", $countones(sel) <= 1, 1);
    if (frame_done === 1'b1) begin
      if (last_fd >= 0) chk("fd_period", cy - last_fd, 16);
      last_fd = cy;
    end
  endtask

  task automatic run_to(int target);
    for (int i = 0; i < 40 && (p % 16) != target; i++) cyc();
    chk("align", p % 16, target);
  endtask

  initial begin
    rst      = 1'b0;
    seg_in   = {7'h30, 7'h24, 7'h79, 7'h40};
    dp_in    = 4'b1010;
    digit_en = 4'hF;
    bright   = 2'd3;
    #1 rst = 1'b1;
    #1;
    chk("rst_seg", seg_out, 7'h7F);
    chk("rst_dp", dp_out, 1'b1);
    chk("rst_sel", sel, 4'h0);
    chk("rst_fd", frame_done, 1'b0);
    chk("rst_idx", scan_idx, 2'd0);
    cyc();
    cyc();
    rst = 1'b0;

    for (int i = 0; i < 34; i++) cyc();

    bright = 2'd1;
    run_to(15);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (sel == 4'b0001) hits++;
    end
    chk("bright1_hits", hits, 1);

    bright = 2'd0;
    run_to(15);
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (sel != 4'b0000) hits++;
    end
    chk("bright0_dark", hits, 0);

    bright   = 2'd3;
    digit_en = 4'b0101;
    run_to(15);
    hits = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      if (sel == 4'b0010 || sel == 4'b1000) hits++;
    end
    chk("disabled_sel", hits, 0);

    digit_en = 4'hF;
    run_to(2);
    seg_in[6:0] = 7'h79;
    cyc();
    chk("midslot_hold", seg_out, 7'h40);
    run_to(1);
    chk("next_slot_seg", seg_out, 7'h79);

    run_to(9);
    chk("pre_rst_sel", sel, 4'b0100);
    rst = 1'b1;
    #1;
    chk("mid_rst_seg", seg_out, 7'h7F);
    chk("mid_rst_sel", sel, 4'h0);
    chk("mid_rst_dp", dp_out, 1'b1);
    chk("mid_rst_idx", scan_idx, 2'd0);
    cyc();
    cyc();
    rst = 1'b0;
    last_fd = -1;
    cyc();
    chk("restart_guard", sel, 4'h0);
    cyc();
    chk("restart_first", sel, 4'b0001);
    for (int i = 0; i < 20; i++) cyc();

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
